// File: rtl/stump_timer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : stump_timer                                                     |
// | Purpose  : Memory-mapped prescaled down-counter with interrupt for the     |
// |            Stump core bus, decoded at 0xFF00-0xFF07.                       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module stump_timer (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] address,
   input  logic [15:0] wr_data,
   input  logic        mem_wen,
   input  logic        mem_ren,
   output logic [15:0] rd_data,
   output logic        sel,
   output logic        irq
);

   localparam logic [12:0] C_WINDOW     = 13'h1FE0;
   localparam logic [2:0]  C_A_CTRL     = 3'd0;
   localparam logic [2:0]  C_A_PRESCALE = 3'd1;
   localparam logic [2:0]  C_A_RELOAD   = 3'd2;
   localparam logic [2:0]  C_A_COUNT    = 3'd3;
   localparam logic [2:0]  C_A_STATUS   = 3'd4;

   logic        r_en;
   logic        r_auto;
   logic        r_irq_en;
   logic [15:0] r_prescale;
   logic [15:0] r_reload;
   logic [15:0] r_count;
   logic        r_expired;
   logic [15:0] r_pre_cnt;

   logic        w_wr;
   logic        w_rd;
   logic        w_tick;
   logic        w_expire;
   logic        w_wr_ctrl;
   logic        w_wr_prescale;
   logic        w_wr_reload;
   logic        w_wr_count;
   logic        w_wr_status;

   assign sel = (address[15:3] == C_WINDOW);

   // A simultaneous read and write strobe is a write; the read is suppressed.
   assign w_wr = sel & mem_wen;
   assign w_rd = sel & mem_ren & ~mem_wen;

   assign w_wr_ctrl     = w_wr & (address[2:0] == C_A_CTRL);
   assign w_wr_prescale = w_wr & (address[2:0] == C_A_PRESCALE);
   assign w_wr_reload   = w_wr & (address[2:0] == C_A_RELOAD);
   assign w_wr_count    = w_wr & (address[2:0] == C_A_COUNT);
   assign w_wr_status   = w_wr & (address[2:0] == C_A_STATUS);

   assign w_tick   = r_en & (r_pre_cnt == r_prescale);
   assign w_expire = w_tick & (r_count == 16'h0000);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pre_cnt <= 16'h0000;
      end else if (!r_en || w_tick || w_wr_count) begin
         r_pre_cnt <= 16'h0000;
      end else begin
         r_pre_cnt <= r_pre_cnt + 16'h0001;
      end
   end

   // Software writes win over the tick update of COUNT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= 16'h0000;
      end else if (w_wr_count) begin
         r_count <= wr_data;
      end else if (w_tick) begin
         if (r_count != 16'h0000) begin
            r_count <= r_count - 16'h0001;
         end else if (r_auto) begin
            r_count <= r_reload;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_en     <= 1'b0;
         r_auto   <= 1'b0;
         r_irq_en <= 1'b0;
      end else if (w_wr_ctrl) begin
         r_en     <= wr_data[0];
         r_auto   <= wr_data[1];
         r_irq_en <= wr_data[2];
      end else if (w_expire && !r_auto) begin
         r_en     <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prescale <= 16'h0000;
         r_reload   <= 16'h0000;
      end else begin
         if (w_wr_prescale) begin
            r_prescale <= wr_data;
         end
         if (w_wr_reload) begin
            r_reload <= wr_data;
         end
      end
   end

   // Hardware expiry beats a same-cycle write-1-to-clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_expired <= 1'b0;
      end else if (w_expire) begin
         r_expired <= 1'b1;
      end else if (w_wr_status && wr_data[0]) begin
         r_expired <= 1'b0;
      end
   end

   always_comb begin
      rd_data = 16'h0000;
      if (w_rd) begin
         case (address[2:0])
            C_A_CTRL:     rd_data = {13'h0000, r_irq_en, r_auto, r_en};
            C_A_PRESCALE: rd_data = r_prescale;
            C_A_RELOAD:   rd_data = r_reload;
            C_A_COUNT:    rd_data = r_count;
            C_A_STATUS:   rd_data = {15'h0000, r_expired};
            default:      rd_data = 16'h0000;
         endcase
      end
   end

   assign irq = r_expired & r_irq_en;

endmodule
`default_nettype wire

// File: tb/tb_stump_timer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_stump_timer                                                  |
// | Purpose  : Directed vector bench for stump_timer.                          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_stump_timer;

   logic        clk;
   logic        rst;
   logic [15:0] address;
   logic [15:0] wr_data;
   logic        mem_wen;
   logic        mem_ren;
   logic [15:0] rd_data;
   logic        sel;
   logic        irq;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic        wen;
      logic        ren;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_rd;
      logic        exp_sel;
      logic        exp_irq;
   } vec_t;

   localparam int C_NVEC = 22;
   vec_t vecs [C_NVEC];

   stump_timer dut (
      .clk     (clk),
      .rst     (rst),
      .address (address),
      .wr_data (wr_data),
      .mem_wen (mem_wen),
      .mem_ren (mem_ren),
      .rd_data (rd_data),
      .sel     (sel),
      .irq     (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One bus cycle: drive at the falling edge, compare 1 ns later, before the
   // rising edge that commits any write.
   task automatic step(input string tag, input logic wen, input logic ren,
                       input logic [15:0] a, input logic [15:0] wd,
                       input logic [15:0] exp_rd, input logic exp_sel, input logic exp_irq);
      @(negedge clk);
      mem_wen = wen;
      mem_ren = ren;
      address = a;
      wr_data = wd;
      #1;
      chk({tag, ".rd_data"}, rd_data, exp_rd);
      chk({tag, ".sel"}, {15'h0, sel}, {15'h0, exp_sel});
      chk({tag, ".irq"}, {15'h0, irq}, {15'h0, exp_irq});
   endtask

   initial begin
      //           wen   ren   addr      wdata     exp_rd    sel   irq
      // one-shot countdown: COUNT=3, PRESCALE=0, CTRL=EN|IRQ_EN
      vecs[0]  = '{1'b0, 1'b1, 16'hFF00, 16'h0000, 16'h0000, 1'b1, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 16'hFF01, 16'h0000, 16'h0000, 1'b1, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 16'hFF03, 16'h0003, 16'h0000, 1'b1, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 16'hFF00, 16'h0005, 16'h0000, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 16'hFF03, 16'h0000, 16'h0003, 1'b1, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 16'hFF03, 16'h0000, 16'h0002, 1'b1, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 16'hFF03, 16'h0000, 16'h0001, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 16'hFF03, 16'h0000, 16'h0000, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 16'hFF04, 16'h0000, 16'h0001, 1'b1, 1'b1};
      vecs[9]  = '{1'b0, 1'b1, 16'hFF00, 16'h0000, 16'h0004, 1'b1, 1'b1};
      vecs[10] = '{1'b0, 1'b1, 16'hFF03, 16'h0000, 16'h0000, 1'b1, 1'b1};
      vecs[11] = '{1'b1, 1'b0, 16'hFF04, 16'h0001, 16'h0000, 1'b1, 1'b1};
      vecs[12] = '{1'b0, 1'b1, 16'hFF04, 16'h0000, 16'h0000, 1'b1, 1'b0};
      // unmapped reads, decode window, write-with-read
      vecs[13] = '{1'b0, 1'b1, 16'hFF05, 16'h0000, 16'h0000, 1'b1, 1'b0};
      vecs[14] = '{1'b0, 1'b1, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b0};
      vecs[15] = '{1'b1, 1'b1, 16'hFF02, 16'hABCD, 16'h0000, 1'b1, 1'b0};
      vecs[16] = '{1'b0, 1'b1, 16'hFF02, 16'h0000, 16'hABCD, 1'b1, 1'b0};
      vecs[17] = '{1'b1, 1'b0, 16'hFF06, 16'hFFFF, 16'h0000, 1'b1, 1'b0};
      vecs[18] = '{1'b0, 1'b1, 16'hFF06, 16'h0000, 16'h0000, 1'b1, 1'b0};
      vecs[19] = '{1'b1, 1'b0, 16'hFF00, 16'hFFF8, 16'h0000, 1'b1, 1'b0};
      vecs[20] = '{1'b0, 1'b1, 16'hFF00, 16'h0000, 16'h0000, 1'b1, 1'b0};
      vecs[21] = '{1'b0, 1'b0, 16'hFF02, 16'h0000, 16'h0000, 1'b1, 1'b0};

      rst     = 1'b1;
      mem_wen = 1'b0;
      mem_ren = 1'b0;
      address = 16'h0000;
      wr_data = 16'h0000;
      #3;
      chk("reset.irq", {15'h0, irq}, 16'h0000);
      chk("reset.rd_data", rd_data, 16'h0000);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < C_NVEC; i++) begin
         step($sformatf("vec%0d", i), vecs[i].wen, vecs[i].ren, vecs[i].addr,
              vecs[i].wdata, vecs[i].exp_rd, vecs[i].exp_sel, vecs[i].exp_irq);
      end

      // Auto-reload: RELOAD=2, COUNT=0, PRESCALE=1, CTRL=EN|AUTO|IRQ_EN
      step("ar.reload",   1'b1, 1'b0, 16'hFF02, 16'h0002, 16'h0000, 1'b1, 1'b0);
      step("ar.count",    1'b1, 1'b0, 16'hFF03, 16'h0000, 16'h0000, 1'b1, 1'b0);
      step("ar.prescale", 1'b1, 1'b0, 16'hFF01, 16'h0001, 16'h0000, 1'b1, 1'b0);
      step("ar.ctrl",     1'b1, 1'b0, 16'hFF00, 16'h0007, 16'h0000, 1'b1, 1'b0);
      step("ar.k0",  1'b0, 1'b1, 16'hFF03, 16'h0000, 16'h0000, 1'b1, 1'b0);
      step("ar.k1",  1'b0, 1'b1, 16'hFF03, 16'h0000, 16'h0000, 1'b1, 1'b0);
      step("ar.k2",  1'b0, 1'b1, 16'hFF04, 16'h0000, 16'h0001, 1'b1, 1'b1);
      step("ar.k3",  1'b1, 1'b0, 16'hFF04, 16'h0001, 16'h0000, 1'b1, 1'b1);
      step("ar.k4",  1'b0, 1'b1, 16'hFF03, 16'h0000, 16'h0001, 1'b1, 1'b0);
      step("ar.k5",  1'b0, 1'b1, 16'hFF03, 16'h0000, 16'h0001, 1'b1, 1'b0);
      step("ar.k6",  1'b0, 1'b1, 16'hFF03, 16'h0000, 16'h0000, 1'b1, 1'b0);
      step("ar.k7",  1'b0, 1'b1, 16'hFF03, 16'h0000, 16'h0000, 1'b1, 1'b0);
      step("ar.k8",  1'b0, 1'b1, 16'hFF04, 16'h0000, 16'h0001, 1'b1, 1'b1);
      step("ar.k9",  1'b1, 1'b0, 16'hFF04, 16'h0001, 16'h0000, 1'b1, 1'b1);
      step("ar.k10", 1'b0, 1'b1, 16'hFF04, 16'h0000, 16'h0000, 1'b1, 1'b0);
      step("ar.k11", 1'b0, 1'b1, 16'hFF03, 16'h0000, 16'h0001, 1'b1, 1'b0);
      step("ar.k12", 1'b0, 1'b1, 16'hFF03, 16'h0000, 16'h0000, 1'b1, 1'b0);
      // clear request lands on the expiry edge: expiry must win
      step("ar.k13", 1'b1, 1'b0, 16'hFF04, 16'h0001, 16'h0000, 1'b1, 1'b0);
      step("ar.k14", 1'b0, 1'b1, 16'hFF04, 16'h0000, 16'h0001, 1'b1, 1'b1);
      // COUNT write on a tick edge overrides the decrement
      step("ar.k15", 1'b1, 1'b0, 16'hFF03, 16'h00FF, 16'h0000, 1'b1, 1'b1);
      step("ar.k16", 1'b0, 1'b1, 16'hFF03, 16'h0000, 16'h00FF, 1'b1, 1'b1);
      step("ar.k17", 1'b0, 1'b1, 16'hFF03, 16'h0000, 16'h00FF, 1'b1, 1'b1);
      step("ar.k18", 1'b0, 1'b1, 16'hFF03, 16'h0000, 16'h00FE, 1'b1, 1'b1);

      // Asynchronous reset between edges while counting with irq high
      #1;
      rst = 1'b1;
      #1;
      chk("arst.count_now", rd_data, 16'h0000);
      chk("arst.irq_now", {15'h0, irq}, 16'h0000);
      step("arst.ctrl",     1'b0, 1'b1, 16'hFF00, 16'h0000, 16'h0000, 1'b1, 1'b0);
      step("arst.prescale", 1'b0, 1'b1, 16'hFF01, 16'h0000, 16'h0000, 1'b1, 1'b0);
      step("arst.reload",   1'b0, 1'b1, 16'hFF02, 16'h0000, 16'h0000, 1'b1, 1'b0);
      step("arst.count",    1'b0, 1'b1, 16'hFF03, 16'h0000, 16'h0000, 1'b1, 1'b0);
      step("arst.status",   1'b0, 1'b1, 16'hFF04, 16'h0000, 16'h0000, 1'b1, 1'b0);
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step($sformatf("post%0d", k), 1'b0, 1'b1, 16'hFF04, 16'h0000, 16'h0000, 1'b1, 1'b0);
      end
      step("post.count", 1'b0, 1'b1, 16'hFF03, 16'h0000, 16'h0000, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
